// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // A writer of x0 never creates a dependency.
    function automatic logic reg_dep(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != REG_X0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush/freeze control with memory-wait watchdog and
// saturating performance counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs1_i,
    input  logic [4:0]       ifid_rs2_i,
    input  logic             ifid_uses_rs2_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rd_i,
    input  logic             branch_taken_i,
    input  logic             exmem_mem_req_i,
    input  logic             dmem_ready_i,
    input  logic             clr_cnt_i,
    output logic             pc_write_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             freeze_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] memwait_cnt_o
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_stall;
    logic       load_use;

    always_comb begin
        mem_stall = exmem_mem_req_i && !dmem_ready_i && (state_q != ERR);
        load_use  = idex_memread_i &&
                    (reg_dep(idex_rd_i, ifid_rs1_i) ||
                     (ifid_uses_rs2_i && reg_dep(idex_rd_i, ifid_rs2_i)));

        // Freeze outranks load-use, which outranks a branch flush.
        freeze_o      = mem_stall;
        ifid_stall_o  = mem_stall || load_use;
        idex_bubble_o = !mem_stall && load_use;
        ifid_flush_o  = !mem_stall && !load_use && branch_taken_i;
        pc_write_o    = !(mem_stall || load_use);
        err_o         = (state_q == ERR);
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ERR:     state_d = ERR;
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .clr (clr_cnt_i),
        .inc (idex_bubble_o),
        .cnt (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .clr (clr_cnt_i),
        .inc (ifid_flush_o),
        .cnt (flush_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_memwait_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .clr (clr_cnt_i),
        .inc (freeze_o),
        .cnt (memwait_cnt_o)
    );

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central pipeline control source for the 5-stage RISC-V core. Generates the stall, flush, bubble and freeze controls that the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC consume.
- Detects load-use hazards and ID-stage branch redirects.
- Freezes the whole pipeline while a data-memory access is outstanding, with a timeout watchdog.
- Keeps saturating performance counters for stall, flush and memory-wait cycles.

Parameters:
- TIMEOUT, 16: maximum consecutive frozen cycles before the error state; legal range 2..255.
- CNT_W, 32: width of each performance counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ifid_rs1_i  in  5  rs1 address of the instruction in ID
- ifid_rs2_i  in  5  rs2 address of the instruction in ID
- ifid_uses_rs2_i  in  1  instruction in ID reads rs2 (R/S/B-type)
- idex_memread_i  in  1  instruction in EX is a load
- idex_rd_i  in  5  destination register of the instruction in EX
- branch_taken_i  in  1  branch resolved taken in ID this cycle
- exmem_mem_req_i  in  1  instruction in MEM performs a load or store
- dmem_ready_i  in  1  data memory completes the access this cycle
- clr_cnt_i  in  1  synchronous clear of all counters
- pc_write_o  out  1  PC update enable
- ifid_stall_o  out  1  IF/ID holds its value
- ifid_flush_o  out  1  IF/ID loads zero (NOP)
- idex_bubble_o  out  1  ID/EX loads zero controls
- freeze_o  out  1  every pipeline register and the PC hold
- err_o  out  1  sticky memory-timeout error
- stall_cnt_o  out  CNT_W  load-use stall cycles
- flush_cnt_o  out  CNT_W  flush cycles
- memwait_cnt_o  out  CNT_W  frozen cycles

Behaviour:
- Reset (async): state=RUN, wait_cnt=0, all counters=0, err_o=0. Control outputs follow the combinational rules below with state=RUN.
- Combinational terms:
  - mem_stall = exmem_mem_req_i & ~dmem_ready_i & (state!=ERR)
  - load_use = idex_memread_i & (idex_rd_i!=0) & (idex_rd_i==ifid_rs1_i | (ifid_uses_rs2_i & idex_rd_i==ifid_rs2_i))
- Priority: freeze > load-use > flush.
  - freeze_o = mem_stall.
  - ifid_stall_o = mem_stall | load_use.
  - idex_bubble_o = ~mem_stall & load_use.
  - ifid_flush_o = ~mem_stall & ~load_use & branch_taken_i. A branch waiting on a load is stalled and re-resolved next cycle.
  - pc_write_o = ~(mem_stall | load_use).
- Control latency: 0 cycles (same-cycle combinational). Counters and the FSM update on posedge clk_i.
- FSM:
  - RUN: if mem_stall, go to MEM_WAIT with wait_cnt=1, or go to ERR if TIMEOUT==1 is ever supported (it is not; minimum is 2). Otherwise stay in RUN with wait_cnt=0.
  - MEM_WAIT: if ~mem_stall, go to RUN with wait_cnt=0. Else if wait_cnt==TIMEOUT-1, go to ERR. Else wait_cnt+1.
  - ERR: terminal until rst_i. err_o=1. freeze_o is forced 0 so the pipeline drains. Hazard and flush logic stays active.
  - Net effect: at most TIMEOUT consecutive cycles with freeze_o=1.
- Dropping exmem_mem_req_i while in MEM_WAIT is treated as completion and returns to RUN.
- Counters:
  - Each increments by 1 in a cycle where its output term is 1: stall_cnt on idex_bubble_o, flush_cnt on ifid_flush_o, memwait_cnt on freeze_o.
  - Each saturates at all-ones.
  - clr_cnt_i has priority over increment; the counter reads 0 the next cycle.
- Reset asserted mid-wait: FSM returns to RUN immediately and freeze_o follows the current inputs.

Decomposition:
- Shared package: FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2) and the x0 register constant.
- One sub-module, sat_counter (parameter W; inputs clk, rst, clr, inc; output cnt), instantiated three times.

Test Plan:
- Load-use on rs1: idex_memread=1, idex_rd=5, ifid_rs1=5 for 1 cycle -> pc_write=0, ifid_stall=1, idex_bubble=1; stall_cnt=1 next cycle.
- x0 and rs2 gating:
  - idex_rd=0 matching rs1 -> no stall.
  - idex_rd=7, ifid_rs2=7, uses_rs2=0 -> no stall.
  - Same with uses_rs2=1 -> stall.
- Branch vs load-use:
  - branch_taken=1 with no hazard -> ifid_flush=1 and pc_write=1; flush_cnt increments.
  - Same cycle with load_use=1 -> flush=0, bubble=1.
- Memory wait: exmem_mem_req=1 with dmem_ready low 3 cycles then high -> freeze_o high exactly 3 cycles, memwait_cnt=3, state back to RUN; load_use asserted concurrently gives idex_bubble=0 while frozen.
- Timeout, TIMEOUT=4: dmem_ready held low -> freeze_o high 4 cycles, err_o=1 from cycle 5 with freeze_o=0. err_o stays 1 until rst_i pulse clears it to 0.
- Saturation and clear, CNT_W=3: 9 consecutive load-use cycles -> stall_cnt stops at 7. clr_cnt_i together with an increment -> 0 next cycle.
